note_sequencer: RTL and testbench

Plays a programmed sequence of up to DEPTH notes by stepping the 4-bit tone code that feeds the tone-to-period lookup. Each note lasts a programmable number of beats, counted against an internal beat prescaler. Also drives a gate to the oscillator/output stage. A host loads the note table through a simple write port, then starts, stops or loops playback.

---
 rtl/note_sequencer_if.sv | 30 +++
 rtl/note_sequencer.sv | 115 +++++++++++
 tb/tb_note_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/note_sequencer_if.sv
// Host-side bundle for the note sequencer: table write port, playback
// controls and the tone/gate outputs toward the oscillator stage.
interface note_sequencer_if #(
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [AW:0]   seq_len;
    logic          loop_en;
    logic          start;
    logic          stop;
    logic [3:0]    tone;
    logic          gate;
    logic          busy;
    logic [AW-1:0] note_idx;
    logic          done;

    modport master (
        output wr_en, wr_addr, wr_data, seq_len, loop_en, start, stop,
        input  tone, gate, busy, note_idx, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, seq_len, loop_en, start, stop,
        output tone, gate, busy, note_idx, done
    );
endinterface

// File: rtl/note_sequencer.sv
// Steps through a programmed note table, holding each tone for dur+1 beats
// of an internal prescaler and gating the output for non-rest entries.
module note_sequencer #(
    parameter int CLOCK_SPEED = 25_000_000,
    parameter int BEAT_HZ     = 8,
    parameter int DEPTH       = 16
) (
    input logic             clk,
    input logic             rst,
    note_sequencer_if.slave bus
);
    localparam int AW       = $clog2(DEPTH);
    localparam int BEAT_DIV = CLOCK_SPEED / BEAT_HZ;
    localparam int PW       = $clog2(BEAT_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(BEAT_DIV - 1);
    localparam logic [AW:0]   LEN_MAX = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

    state_t        state, state_nxt;
    logic [7:0]    mem [DEPTH];
    logic [7:0]    entry;
    logic [AW-1:0] idx;
    logic [AW:0]   len;
    logic [PW-1:0] presc;
    logic [4:0]    beats_left;
    logic [3:0]    tone;
    logic          gate;
    logic [AW-1:0] note_idx;
    logic          done;
    logic          go, tick, note_end, last;

    // Table is deliberately not reset; the read is taken at the edge that ends LOAD,
    // so a write landing on that same edge is not yet visible.
    always_ff @(posedge clk)
        if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;

    assign entry = mem[idx];

    always_comb begin
        go        = bus.start && !bus.stop && (bus.seq_len != '0);
        tick      = (state == PLAY) && (presc == PRE_MAX);
        note_end  = tick && (beats_left == 5'd1);
        last      = ({1'b0, idx} == len - 1'b1);
        state_nxt = state;
        case (state)
            IDLE:    if (go) state_nxt = LOAD;
            LOAD:    state_nxt = PLAY;
            PLAY:    if (note_end) state_nxt = (!last || bus.loop_en) ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.stop) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            len        <= '0;
            presc      <= '0;
            beats_left <= '0;
            tone       <= 4'd2;
            gate       <= 1'b0;
            note_idx   <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (bus.stop) begin
                gate       <= 1'b0;
                presc      <= '0;
                beats_left <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        presc      <= '0;
                        beats_left <= '0;
                        if (go) begin
                            len <= (bus.seq_len > LEN_MAX) ? LEN_MAX : bus.seq_len;
                            idx <= '0;
                        end
                    end
                    LOAD: begin
                        tone       <= entry[3:0];
                        gate       <= (entry[3:0] != 4'hF);
                        beats_left <= {1'b0, entry[7:4]} + 5'd1;
                        note_idx   <= idx;
                        presc      <= '0;
                    end
                    PLAY: begin
                        presc <= tick ? '0 : presc + 1'b1;
                        if (tick) beats_left <= beats_left - 5'd1;
                        if (note_end) begin
                            if (!last)            idx <= idx + 1'b1;
                            else if (bus.loop_en) idx <= '0;
                            else begin
                                gate <= 1'b0;
                                done <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.tone     = tone;
    assign bus.gate     = gate;
    assign bus.busy     = (state != IDLE);
    assign bus.note_idx = note_idx;
    assign bus.done     = done;
endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench: each playback command expands the note table into a
// per-cycle timeline of expected outputs, which a monitor compares each cycle.
module tb_note_sequencer;
    localparam int BD = 4;

    typedef struct packed {
        logic       busy;
        logic       gate;
        logic [3:0] tone;
        logic [3:0] idx;
        logic       done;
    } snap_t;

    logic clk, rst;
    note_sequencer_if #(.DEPTH(16)) bus ();

    note_sequencer #(.CLOCK_SPEED(40), .BEAT_HZ(10), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         checks = 0;
    int         errors = 0;
    snap_t      exp_q[$];
    snap_t      tl[$];
    logic [7:0] model_mem [16];
    logic [3:0] m_tone;
    logic [3:0] m_idx;
    logic       m_gate;

    function automatic snap_t mk(logic b, logic g, logic [3:0] t, logic [3:0] i, logic d);
        snap_t s;
        s.busy = b; s.gate = g; s.tone = t; s.idx = i; s.done = d;
        return s;
    endfunction

    function automatic void chk(string n, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            snap_t e;
            e = exp_q.pop_front();
            chk("busy", {7'd0, bus.busy}, {7'd0, e.busy});
            chk("gate", {7'd0, bus.gate}, {7'd0, e.gate});
            chk("tone", {4'd0, bus.tone}, {4'd0, e.tone});
            chk("note_idx", {4'd0, bus.note_idx}, {4'd0, e.idx});
            chk("done", {7'd0, bus.done}, {7'd0, e.done});
        end
    end

    // One pass over the table: each note is one LOAD cycle still showing the
    // previous note, then (dur+1) beats of BD cycles showing the new one.
    function automatic void gen_pass(int l, bit final_pass);
        for (int i = 0; i < l; i++) begin
            int n;
            tl.push_back(mk(1'b1, m_gate, m_tone, m_idx, 1'b0));
            m_tone = model_mem[i][3:0];
            m_gate = (m_tone != 4'hF);
            m_idx  = 4'(i);
            n = (int'(model_mem[i][7:4]) + 1) * BD;
            repeat (n) tl.push_back(mk(1'b1, m_gate, m_tone, m_idx, 1'b0));
        end
        if (final_pass) begin
            m_gate = 1'b0;
            tl.push_back(mk(1'b0, 1'b0, m_tone, m_idx, 1'b1));
            tl.push_back(mk(1'b0, 1'b0, m_tone, m_idx, 1'b0));
        end
    endfunction

    task automatic wait_drain();
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d entries left, required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a[3:0];
        bus.wr_data = d;
        model_mem[a] = d;
        @(posedge clk);
        #2;
        bus.wr_en = 1'b0;
    endtask

    // stop_at: -1 none, 0 together with start, k>0 stop sampled k edges after start.
    // wr_at>0 writes (wa,wd) k edges after start; the model applies it after pass 0.
    task automatic run(input int sl, input int passes, input int stop_at,
                       input int wr_at, input logic [3:0] wa, input logic [7:0] wd);
        int    l, lp, t;
        snap_t lead, s;
        l  = (sl > 16) ? 16 : sl;
        lp = -1;
        tl.delete();
        lead = mk(1'b0, 1'b0, m_tone, m_idx, 1'b0);
        if (l == 0 || stop_at == 0) begin
            repeat (6) tl.push_back(lead);
        end else begin
            for (int p = 0; p < passes; p++) begin
                if (p == passes - 1) lp = tl.size();
                gen_pass(l, p == passes - 1);
                if (p == 0 && wr_at > 0) model_mem[wa] = wd;
            end
        end
        t = tl.size();
        if (stop_at > 0 && (l == 0 || stop_at > t - 2)) stop_at = -1;
        if (stop_at > 0) begin
            s  = tl[stop_at - 1];
            tl = tl[0:stop_at - 1];
            m_tone = s.tone;
            m_idx  = s.idx;
            m_gate = 1'b0;
            tl.push_back(mk(1'b0, 1'b0, s.tone, s.idx, 1'b0));
            tl.push_back(mk(1'b0, 1'b0, s.tone, s.idx, 1'b0));
        end
        exp_q.push_back(lead);
        foreach (tl[i]) exp_q.push_back(tl[i]);
        bus.seq_len = sl[4:0];
        bus.loop_en = (passes > 1);
        bus.start   = 1'b1;
        bus.stop    = (stop_at == 0);
        for (int c = 0; c < tl.size(); c++) begin
            @(posedge clk);
            #2;
            bus.start   = 1'b0;
            bus.stop    = (stop_at > 0 && c + 1 == stop_at);
            if (passes > 1 && c == lp) bus.loop_en = 1'b0;
            bus.wr_en   = (wr_at > 0 && c + 1 == wr_at);
            bus.wr_addr = wa;
            bus.wr_data = wd;
        end
        bus.wr_en   = 1'b0;
        bus.stop    = 1'b0;
        bus.loop_en = 1'b0;
        wait_drain();
    endtask

    initial begin
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.seq_len = 0;
        bus.loop_en = 0; bus.start = 0; bus.stop = 0;
        m_tone = 4'd2; m_idx = 4'd0; m_gate = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_tone", {4'd0, bus.tone}, 8'd2);
        chk("rst_gate", {7'd0, bus.gate}, 8'd0);
        chk("rst_busy", {7'd0, bus.busy}, 8'd0);
        chk("rst_idx", {4'd0, bus.note_idx}, 8'd0);
        chk("rst_done", {7'd0, bus.done}, 8'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        wr(0, 8'h17);
        run(1, 1, -1, -1, 4'd0, 8'h00);
        wr(0, 8'h02); wr(1, 8'h0F); wr(2, 8'h15);
        run(3, 1, -1, -1, 4'd0, 8'h00);
        run(3, 2, -1, -1, 4'd0, 8'h00);
        run(3, 1, 0, -1, 4'd0, 8'h00);
        run(3, 1, 3, -1, 4'd0, 8'h00);
        run(0, 1, -1, -1, 4'd0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            int du, tn;
            du = $urandom_range(0, 1);
            tn = $urandom_range(0, 15);
            wr(i, 8'(du * 16 + tn));
        end
        run(31, 2, -1, -1, 4'd0, 8'h00);
        wr(0, 8'h02); wr(1, 8'h0F); wr(2, 8'h15);
        run(3, 2, -1, 3, 4'd0, 8'h1A);

        // Asynchronous reset in the middle of a note.
        wr(0, 8'h17);
        bus.seq_len = 5'd3;
        bus.start   = 1'b1;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        chk("pre_rst_tone", {4'd0, bus.tone}, 8'd7);
        rst = 1'b1;
        #1;
        chk("arst_tone", {4'd0, bus.tone}, 8'd2);
        chk("arst_gate", {7'd0, bus.gate}, 8'd0);
        chk("arst_busy", {7'd0, bus.busy}, 8'd0);
        chk("arst_idx", {4'd0, bus.note_idx}, 8'd0);
        chk("arst_done", {7'd0, bus.done}, 8'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        m_tone = 4'd2; m_idx = 4'd0; m_gate = 1'b0;
        repeat (8) exp_q.push_back(mk(1'b0, 1'b0, 4'd2, 4'd0, 1'b0));
        wait_drain();
        run(3, 1, -1, -1, 4'd0, 8'h00);

        for (int r = 0; r < 25; r++) begin
            int nw, sl, ps, sa;
            nw = $urandom_range(1, 4);
            for (int k = 0; k < nw; k++) begin
                int du, tn;
                du = $urandom_range(0, 3);
                tn = ($urandom_range(0, 4) == 0) ? 15 : $urandom_range(0, 15);
                wr($urandom_range(0, 15), 8'(du * 16 + tn));
            end
            sl = $urandom_range(0, 31);
            ps = $urandom_range(1, 2);
            case ($urandom_range(0, 5))
                0:       sa = $urandom_range(1, 60);
                1:       sa = 0;
                default: sa = -1;
            endcase
            run(sl, ps, sa, -1, 4'd0, 8'h00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
